// File: rtl/axi_rd_pkg.sv
// Shared types and helpers for the AXI-style burst read initiator.
package axi_rd_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} state_t;

  localparam int ARBURST_W = 4;

  // floor(log2(remaining)) capped at max_log; remaining==0 yields 0
  function automatic logic [ARBURST_W-1:0] burst_exp(input logic [31:0] remaining,
                                                     input int max_log);
    int msb;
    msb = 0;
    for (int i = 0; i < 32; i++)
      if (remaining[i]) msb = i;
    if (msb > max_log) msb = max_log;
    return msb[ARBURST_W-1:0];
  endfunction

endpackage

// File: rtl/burst_len_calc.sv
// Largest power-of-two burst exponent that fits the remaining word count.
module burst_len_calc
  import axi_rd_pkg::*;
#(
  parameter int LW            = 24,
  parameter int MAX_BURST_LOG = 4
) (
  input  logic [LW-1:0]        remaining,
  output logic [ARBURST_W-1:0] burst_log
);

  assign burst_log = burst_exp(32'(remaining), MAX_BURST_LOG);

endmodule

// File: rtl/axi_burst_reader.sv
// Fetches a contiguous word block as a series of power-of-two read bursts
// and streams each accepted beat into the local buffer write port.
module axi_burst_reader
  import axi_rd_pkg::*;
#(
  parameter int DW            = 32,
  parameter int AW            = 32,
  parameter int LW            = 24,
  parameter int MAX_BURST_LOG = 4,
  parameter int BUF_AW        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [LW-1:0]        num_words,
  input  logic [BUF_AW-1:0]    buf_base,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        araddr,
  output logic                 arvalid,
  output logic [ARBURST_W-1:0] arburst,
  input  logic                 arready,
  input  logic [DW-1:0]        rdata,
  input  logic                 rvalid,
  input  logic                 rlast,
  output logic                 buf_we,
  output logic [BUF_AW-1:0]    buf_waddr,
  output logic [DW-1:0]        buf_wdata
);

  localparam int BW = MAX_BURST_LOG + 1;

  state_t                 state;
  logic [AW-1:0]          cur_addr;
  logic [LW-1:0]          remaining;
  logic [BUF_AW-1:0]      wptr;
  logic [BW-1:0]          expected, beat_cnt, beats_now;
  logic [ARBURST_W-1:0]   exp_log;
  logic                   take, term;

  burst_len_calc #(.LW(LW), .MAX_BURST_LOG(MAX_BURST_LOG)) u_len (
    .remaining (remaining),
    .burst_log (exp_log)
  );

  // beats_now counts the current beat too, so termination sees the final total
  assign take      = (state == DATA) && rvalid && (beat_cnt < expected);
  assign beats_now = beat_cnt + BW'(take);
  assign term      = (rvalid && rlast) || (beats_now == expected);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      arburst   <= '0;
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      wptr      <= '0;
      expected  <= '0;
      beat_cnt  <= '0;
    end else begin
      arvalid <= 1'b0;
      buf_we  <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (num_words != '0) begin
            cur_addr  <= base_addr;
            remaining <= num_words;
            wptr      <= buf_base;
            busy      <= 1'b1;
            state     <= REQ;
          end else begin
            state <= FIN;
          end
        end
        REQ: if (arready) begin
          arvalid  <= 1'b1;
          araddr   <= cur_addr;
          arburst  <= exp_log;
          expected <= BW'(1) << exp_log;
          beat_cnt <= '0;
          state    <= DATA;
        end
        DATA: begin
          if (take) begin
            buf_we    <= 1'b1;
            buf_waddr <= wptr;
            buf_wdata <= rdata;
            wptr      <= wptr + BUF_AW'(1);
            beat_cnt  <= beats_now;
          end
          // short bursts resume at cur_addr, so nothing is lost or repeated
          if (term) begin
            cur_addr  <= cur_addr + AW'(beats_now);
            remaining <= remaining - LW'(beats_now);
            state     <= (remaining == LW'(beats_now)) ? FIN : REQ;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench: memory responder with mem[i]=i, write/request scoreboards.
module tb_axi_burst_reader;

  logic        clk, rst_n, start;
  logic [31:0] base_addr;
  logic [23:0] num_words;
  logic [15:0] buf_base;
  logic        busy, done, arvalid, arready, rvalid, rlast, buf_we;
  logic [31:0] araddr, rdata, buf_wdata;
  logic [3:0]  arburst;
  logic [15:0] buf_waddr;

  axi_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .buf_base(buf_base), .busy(busy), .done(done),
    .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .buf_we(buf_we),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int done_cnt = 0, we_cnt = 0;
  int rlast_at = 0, extra_beats = 0;
  bit ar_block = 0, sb_en = 1;
  logic [47:0] exp_wr[$];
  logic [35:0] exp_ar[$], ar_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Responder: one burst at a time, arready low while streaming
  initial begin
    logic [31:0] a;
    int n, idx;
    bit active;
    active = 0; n = 0; idx = 0; a = '0;
    arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (!active && arvalid) begin
        a = araddr; n = (1 << arburst) + extra_beats; extra_beats = 0;
        idx = 0; active = 1;
      end
      if (active) begin
        rvalid = 1'b1;
        rdata  = 32'(a + 32'(idx));
        rlast  = (idx == n - 1) || (rlast_at != 0 && idx + 1 == rlast_at);
        if (rlast) begin active = 0; rlast_at = 0; end
        idx++;
      end else begin
        rvalid = 1'b0; rlast = 1'b0; rdata = '0;
      end
      arready = !active && !ar_block;
    end
  end

  // Monitor: sample shortly after each rising edge
  initial begin
    logic rdy_q, prev_arv;
    logic [47:0] e;
    prev_arv = 1'b0;
    forever begin
      @(posedge clk);
      rdy_q = arready;
      #1;
      if (done) done_cnt++;
      if (arvalid) begin
        check("ar_proto", {62'd0, prev_arv, rdy_q}, 64'd1);
        ar_log.push_back({araddr, arburst});
      end
      prev_arv = arvalid;
      if (buf_we) begin
        we_cnt++;
        if (sb_en) begin
          check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", 64'(buf_waddr), 64'(e[47:32]));
            check("wr_data", 64'(buf_wdata), 64'(e[31:0]));
          end
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [23:0] n, input logic [15:0] bb);
    @(negedge clk);
    start = 1'b1; base_addr = b; num_words = n; buf_base = bb;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc, busy_low;
    bit seen;
    cyc = 0; busy_low = 0; seen = 0;
    while (!seen && cyc < 1000) begin
      if (done) seen = 1;
      else begin
        if (!busy) busy_low++;
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_held"}, 64'(busy_low), 64'd0);
  endtask

  task automatic expect_run(input logic [31:0] b, input int n, input logic [15:0] bb);
    for (int i = 0; i < n; i++) exp_wr.push_back({16'(bb + 16'(i)), 32'(b + 32'(i))});
  endtask

  task automatic compare_ar(input string tag);
    check({tag, "_ar_count"}, 64'(ar_log.size()), 64'(exp_ar.size()));
    for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
      check({tag, "_ar"}, 64'(ar_log[i]), 64'(exp_ar[i]));
    check({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    exp_ar.delete(); ar_log.delete(); exp_wr.delete();
  endtask

  initial begin
    int d0, w0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; buf_base = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({busy, done, arvalid, araddr, arburst, buf_we, buf_waddr, buf_wdata}), 64'd0);
    rst_n = 1'b1;

    // 37 words -> 16,16,4,1
    expect_run(100, 37, 0);
    exp_ar.push_back({32'd100, 4'd4}); exp_ar.push_back({32'd116, 4'd4});
    exp_ar.push_back({32'd132, 4'd2}); exp_ar.push_back({32'd136, 4'd0});
    d0 = done_cnt;
    do_start(100, 37, 0);
    wait_done("w37");
    repeat (5) @(negedge clk);
    check("w37_done_once", 64'(done_cnt - d0), 64'd1);
    compare_ar("w37");

    // zero-length command
    d0 = done_cnt; w0 = we_cnt;
    do_start(5, 0, 9);
    check("zero_done_early", 64'(done), 64'd0);
    @(negedge clk);
    check("zero_done_2cyc", 64'(done), 64'd1);
    repeat (5) @(negedge clk);
    check("zero_no_we", 64'(we_cnt - w0), 64'd0);
    check("zero_done_once", 64'(done_cnt - d0), 64'd1);
    compare_ar("zero");

    // arready held low after start
    @(posedge clk); ar_block = 1;
    expect_run(7, 1, 200);
    exp_ar.push_back({32'd7, 4'd0});
    do_start(7, 1, 200);
    repeat (10) @(negedge clk);
    check("hold_no_arvalid", 64'(ar_log.size()), 64'd0);
    @(posedge clk); ar_block = 0;
    wait_done("hold");
    repeat (3) @(negedge clk);
    compare_ar("hold");

    // early rlast on beat 3 of a 16-beat burst
    rlast_at = 3;
    expect_run(0, 16, 0);
    exp_ar.push_back({32'd0, 4'd4});  exp_ar.push_back({32'd3, 4'd3});
    exp_ar.push_back({32'd11, 4'd2}); exp_ar.push_back({32'd15, 4'd0});
    do_start(0, 16, 0);
    wait_done("short");
    repeat (3) @(negedge clk);
    compare_ar("short");

    // responder over-delivers 2 beats on the first burst
    extra_beats = 2;
    w0 = we_cnt;
    expect_run(300, 17, 500);
    exp_ar.push_back({32'd300, 4'd4}); exp_ar.push_back({32'd316, 4'd0});
    do_start(300, 17, 500);
    wait_done("extra");
    repeat (3) @(negedge clk);
    check("extra_we_cnt", 64'(we_cnt - w0), 64'd17);
    compare_ar("extra");

    // reset in the middle of a burst
    sb_en = 0; w0 = we_cnt;
    do_start(1000, 16, 0);
    for (int i = 0; i < 100 && we_cnt < w0 + 3; i++) @(negedge clk);
    check("rst_reached_data", 64'(we_cnt >= w0 + 3), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_outs", 64'({busy, done, arvalid, araddr, arburst, buf_we, buf_waddr, buf_wdata}), 64'd0);
    sb_en = 1;
    repeat (25) @(negedge clk);
    ar_log.delete();
    expect_run(50, 4, 40);
    exp_ar.push_back({32'd50, 4'd2});
    do_start(50, 4, 40);
    wait_done("post_rst");
    repeat (3) @(negedge clk);
    compare_ar("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
